// File: rtl/dma_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package : dma_arb_pkg
// Brief   : Shared state encoding and default sizing for the DMA bus arbiter.
// Rev     : 1.0  initial release
// ============================================================================
package dma_arb_pkg;

    localparam int WORD_SIZE_DEF   = 16;
    localparam int BLOCK_BEATS_DEF = 4;
    localparam int NUM_BLOCKS_DEF  = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWN   = 2'd1,
        ARB_STEAL = 2'd2
    } arb_state_t;

    // Counter width that stays legal when a modulus of 1 is configured
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : dma_bus_arbiter_if
// Brief     : BR/BG handshake, CPU data-port status and arbiter status outputs.
// Rev       : 1.0  initial release
// ============================================================================
interface dma_bus_arbiter_if
    import dma_arb_pkg::*;
#(
    parameter int WORD_SIZE  = WORD_SIZE_DEF,
    parameter int NUM_BLOCKS = NUM_BLOCKS_DEF
) ();

    logic                             BR;
    logic                             dma_write;
    logic                             cpu_req;
    logic                             cpu_mem_busy;
    logic                             BG;
    logic                             mem_sel;
    logic                             cpu_stall;
    logic [cnt_width(NUM_BLOCKS)-1:0] blk_cnt;
    logic [WORD_SIZE-1:0]             grant_cycles;

    modport master (
        input  BR, dma_write, cpu_req, cpu_mem_busy,
        output BG, mem_sel, cpu_stall, blk_cnt, grant_cycles
    );

    modport slave (
        output BR, dma_write, cpu_req, cpu_mem_busy,
        input  BG, mem_sel, cpu_stall, blk_cnt, grant_cycles
    );

endinterface
`default_nettype wire

// File: rtl/dma_beat_counter.sv
`default_nettype none
// ============================================================================
// Module : dma_beat_counter
// Brief  : Beat counter within a block and block counter within a grant.
// Rev    : 1.0  initial release
// ============================================================================
module dma_beat_counter
    import dma_arb_pkg::*;
#(
    parameter int BLOCK_BEATS = BLOCK_BEATS_DEF,
    parameter int NUM_BLOCKS  = NUM_BLOCKS_DEF
) (
    input  wire logic                             clk,
    input  wire logic                             rst,
    input  wire logic                             i_en,
    input  wire logic                             i_clr,
    output logic                                  o_blk_wrap,
    output logic [cnt_width(NUM_BLOCKS)-1:0]      o_blk_cnt
);

    localparam int BEAT_W = cnt_width(BLOCK_BEATS);
    localparam int BLK_W  = cnt_width(NUM_BLOCKS);
    localparam logic [BEAT_W-1:0] C_BEAT_LAST = BEAT_W'(BLOCK_BEATS - 1);
    localparam logic [BLK_W-1:0]  C_BLK_LAST  = BLK_W'(NUM_BLOCKS - 1);

    logic [BEAT_W-1:0] r_beat;
    logic [BLK_W-1:0]  r_blk;

    // Pulse on the beat that completes a block
    assign o_blk_wrap = i_en && (r_beat == C_BEAT_LAST);
    assign o_blk_cnt  = r_blk;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_beat <= '0;
            r_blk  <= '0;
        end else if (i_en) begin
            if (r_beat == C_BEAT_LAST) begin
                r_beat <= '0;
                r_blk  <= (r_blk == C_BLK_LAST) ? '0 : r_blk + 1'b1;
            end else begin
                r_beat <= r_beat + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dma_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : dma_bus_arbiter
// Brief  : Grants the shared data-memory port to the DMA via BR/BG while the
//          CPU has no access in flight; stalls the CPU during DMA ownership.
//          Define DMA_CYCLE_STEAL_EN to let a waiting CPU access through
//          between DMA blocks.
// Rev    : 1.0  initial release
// ============================================================================
module dma_bus_arbiter
    import dma_arb_pkg::*;
#(
    parameter int WORD_SIZE   = WORD_SIZE_DEF,
    parameter int BLOCK_BEATS = BLOCK_BEATS_DEF,
    parameter int NUM_BLOCKS  = NUM_BLOCKS_DEF
) (
    input  wire logic          Clk,
    input  wire logic          Reset,
    dma_bus_arbiter_if.master  bus
);

    arb_state_t                       r_state;
    arb_state_t                       w_next_state;
    logic                             w_bg;
    logic                             w_cnt_en;
    logic                             w_cnt_clr;
    logic                             w_blk_wrap;
    logic [cnt_width(NUM_BLOCKS)-1:0] w_blk_cnt;
    logic [WORD_SIZE-1:0]             r_grant_cycles;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (bus.BR && !bus.cpu_mem_busy) begin
                    w_next_state = ARB_OWN;
                end
            end
            ARB_OWN: begin
                // Release takes precedence over a coincident block boundary
                if (!bus.BR) begin
                    w_next_state = ARB_IDLE;
`ifdef DMA_CYCLE_STEAL_EN
                end else if (w_blk_wrap && bus.cpu_req) begin
                    w_next_state = ARB_STEAL;
`endif
                end
            end
`ifdef DMA_CYCLE_STEAL_EN
            ARB_STEAL: begin
                w_next_state = bus.BR ? ARB_OWN : ARB_IDLE;
            end
`endif
            default: w_next_state = ARB_IDLE;
        endcase
    end

    // BG is a pure decode of the state register, so it carries no input path
    always_comb begin
        w_bg          = (r_state == ARB_OWN);
        bus.BG        = w_bg;
        bus.mem_sel   = w_bg;
        bus.cpu_stall = w_bg & bus.cpu_req;
    end

    assign w_cnt_en  = w_bg & bus.dma_write;
    assign w_cnt_clr = (w_next_state == ARB_IDLE);

    dma_beat_counter #(
        .BLOCK_BEATS (BLOCK_BEATS),
        .NUM_BLOCKS  (NUM_BLOCKS)
    ) u_beat_counter (
        .clk        (Clk),
        .rst        (Reset),
        .i_en       (w_cnt_en),
        .i_clr      (w_cnt_clr),
        .o_blk_wrap (w_blk_wrap),
        .o_blk_cnt  (w_blk_cnt)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_grant_cycles <= '0;
        end else if (w_bg && (r_grant_cycles != '1)) begin
            r_grant_cycles <= r_grant_cycles + 1'b1;
        end
    end

    assign bus.blk_cnt      = w_blk_cnt;
    assign bus.grant_cycles = r_grant_cycles;

endmodule
`default_nettype wire
